// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Round-robin scheduler that shares one uart_tx serializer between NREQ
// byte-stream requesters. A requester raises reqIn, is granted the line and
// then hands over bytes one at a time. Each accepted byte is loaded into
// txData8 and launched with a single txStart pulse. The grant is released on
// the last byte, after MAX_FRAME bytes, when the requester drops reqIn, or
// when uart_tx fails to raise txBusy within START_TO cycles of txStart.
//
// Parameters
//   NREQ       number of requesters (2..8)
//   START_TO   cycles allowed for txBusy to rise after txStart (2..255)
//   MAX_FRAME  bytes per grant before a forced release (1..255)
//
// Ports (all on rising edge of clkUtx, rst synchronous active-high)
//   reqIn      [NREQ]    requester i wants the line (level, held per frame)
//   reqValid   [NREQ]    requester i presents a byte
//   reqData8   [8*NREQ]  packed bytes, slice i = [8i+7:8i]
//   reqLast    [NREQ]    presented byte closes the frame
//   reqReady   [NREQ]    one-cycle accept pulse to the owner
//   grant      [NREQ]    one-hot current owner, zero when idle
//   txData8    [8]       byte to uart_tx, held until the next load
//   txStart              one-cycle start pulse to uart_tx
//   txBusy               uart_tx busy flag
//   errTimeout           one-cycle pulse when txBusy never rose
//   schedIdle            high only while no requester owns the line
// -----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int NREQ      = 4,
  parameter int START_TO  = 16,
  parameter int MAX_FRAME = 32
) (
  input  logic              clkUtx,
  input  logic              rst,
  input  logic [NREQ-1:0]   reqIn,
  input  logic [NREQ-1:0]   reqValid,
  input  logic [8*NREQ-1:0] reqData8,
  input  logic [NREQ-1:0]   reqLast,
  output logic [NREQ-1:0]   reqReady,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        txData8,
  output logic              txStart,
  input  logic              txBusy,
  output logic              errTimeout,
  output logic              schedIdle
);

  localparam int IDXW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;       // last released owner
  logic [IDXW-1:0]   g_q, g_d;           // current owner index
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              err_to_q, err_to_d;
  logic              last_q, last_d;     // byte in flight closes the frame
  logic [7:0]        bcnt_q, bcnt_d;     // bytes sent under this grant
  logic [7:0]        tcnt_q, tcnt_d;     // cycles waited for txBusy
  logic [IDXW-1:0]   pick;

  // Round-robin search starting just after ptr. The loop walks the offsets
  // from lowest to highest priority so the last match wins; offset NREQ is
  // ptr itself, which therefore only wins when nobody else is asking.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] sel;
    int              idx;
    sel = ptr;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) sel = IDXW'(idx);
    end
    return sel;
  endfunction

  assign pick = rr_pick(reqIn, ptr_q);

  // NOTE: every variable gets its hold/default value before the case so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    grant_d     = grant_q;
    req_ready_d = '0;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    err_to_d    = 1'b0;
    last_d      = last_q;
    bcnt_d      = bcnt_q;
    tcnt_d      = tcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (|reqIn) begin
          g_d     = pick;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          bcnt_d  = '0;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        if (reqValid[g_q]) begin
          tx_data_d   = reqData8[{g_q, 3'b000} +: 8];
          req_ready_d = grant_q;
          last_d      = reqLast[g_q];
          bcnt_d      = bcnt_q + 8'd1;
          state_d     = S_START;
        end else if (!reqIn[g_q]) begin
          grant_d = '0;
          ptr_d   = g_q;
          state_d = S_IDLE;
        end
      end

      // A busy left over from an earlier byte holds the launch back.
      S_START: begin
        if (!txBusy) begin
          tx_start_d = 1'b1;
          tcnt_d     = '0;
          state_d    = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (txBusy) begin
          state_d = S_WAIT_DONE;
        end else if (tcnt_q == 8'(START_TO - 1)) begin
          err_to_d = 1'b1;
          grant_d  = '0;
          ptr_d    = g_q;
          state_d  = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      S_WAIT_DONE: begin
        if (!txBusy) begin
          if (last_q || (bcnt_q == 8'(MAX_FRAME))) begin
            grant_d = '0;
            ptr_d   = g_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_GRANT;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clkUtx) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDXW'(NREQ - 1);
      g_q         <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      err_to_q    <= 1'b0;
      last_q      <= 1'b0;
      bcnt_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      err_to_q    <= err_to_d;
      last_q      <= last_d;
      bcnt_q      <= bcnt_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign reqReady   = req_ready_q;
  assign grant      = grant_q;
  assign txData8    = tx_data_q;
  assign txStart    = tx_start_q;
  assign errTimeout = err_to_q;
  assign schedIdle  = (state_q == S_IDLE);

endmodule
